// File: rtl/seven_segment_pkg.sv
// ============================================================================
// Module : seven_segment_pkg
// Brief  : Shared digit type, controller states and hex-to-segment decode.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package seven_segment_pkg;

  typedef struct packed {
    logic [3:0] value;
    logic       dot;
    logic       blank;
    logic       blink;
  } digit_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    APPLY   = 2'd2
  } ctrl_state_e;

  localparam digit_t RESET_DIGIT = '{value: 4'h0, dot: 1'b0, blank: 1'b1, blink: 1'b0};

  // Segment bit0 = a .. bit6 = g, active high.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    logic [6:0] seg;
    case (hex)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seven_segment_lz_blank.sv
// ============================================================================
// Module : seven_segment_lz_blank
// Brief  : Combinational leading-zero mask over the active digit array.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module seven_segment_lz_blank
  import seven_segment_pkg::*;
#(
  parameter int NUM_DISPLAYS = 4
) (
  input  logic                         en_i,
  input  digit_t [NUM_DISPLAYS-1:0]    digits_i,
  output logic   [NUM_DISPLAYS-1:0]    dark_o
);

  logic higher_clear;
  logic unused_fields;

  // Scan from the most significant digit; a digit is dark while everything above it shows nothing.
  always_comb begin
    dark_o       = '0;
    higher_clear = 1'b1;
    for (int i = NUM_DISPLAYS - 1; i > 0; i--) begin
      dark_o[i]    = en_i && (digits_i[i].value == 4'h0) && higher_clear;
      higher_clear = higher_clear && ((digits_i[i].value == 4'h0) || digits_i[i].blank);
    end
  end

  assign unused_fields = ^digits_i;

endmodule

`default_nettype wire

// File: rtl/seven_segment_frame_ctrl.sv
// ============================================================================
// Module : seven_segment_frame_ctrl
// Brief  : Shadow/active frame buffer with frame-aligned commit, decode and
//          leading-zero blanking. Optional blinking via SEVSEG_BLINK_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module seven_segment_frame_ctrl
  import seven_segment_pkg::*;
#(
  parameter int NUM_DISPLAYS   = 4,
  parameter int REFRESH_PERIOD = 100000,
  parameter int BLINK_FRAMES   = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              wr_valid_i,
  output logic                              wr_ready_o,
  input  logic [$clog2(NUM_DISPLAYS)-1:0]   wr_index_i,
  input  logic [3:0]                        wr_value_i,
  input  logic                              wr_dot_i,
  input  logic                              wr_blank_i,
  input  logic                              wr_blink_i,
  input  logic                              commit_valid_i,
  output logic                              commit_ready_o,
  input  logic                              lz_blank_en_i,
  output logic                              pending_o,
  output logic                              frame_tick_o,
  output logic [NUM_DISPLAYS-1:0][6:0]      displays_o,
  output logic [NUM_DISPLAYS-1:0]           dots_o
);

  localparam int IDX_W = $clog2(NUM_DISPLAYS);
  localparam int CNT_W = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;

  ctrl_state_e state_q, state_d;
  logic [CNT_W-1:0] frame_cnt_q;
  digit_t [NUM_DISPLAYS-1:0] shadow_q;
  digit_t [NUM_DISPLAYS-1:0] active_q;
  digit_t wr_digit;
  logic wr_fire;
  logic blink_on;
  logic [NUM_DISPLAYS-1:0] lz_dark;

  // Frame counter
  assign frame_tick_o = (frame_cnt_q == CNT_W'(REFRESH_PERIOD - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else if (frame_tick_o) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_q + 1'b1;
    end
  end

  // Commit FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    wr_ready_o     = 1'b0;
    commit_ready_o = 1'b0;
    pending_o      = 1'b0;
    case (state_q)
      IDLE: begin
        wr_ready_o     = !rst;
        commit_ready_o = !rst;
        if (commit_valid_i && commit_ready_o) begin
          state_d = PENDING;
        end
      end
      PENDING: begin
        pending_o = 1'b1;
        if (frame_tick_o) begin
          state_d = APPLY;
        end
      end
      APPLY: begin
        pending_o = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Shadow and active buffers
  assign wr_fire = wr_valid_i && wr_ready_o;

  always_comb begin
    wr_digit       = RESET_DIGIT;
    wr_digit.value = wr_value_i;
    wr_digit.dot   = wr_dot_i;
    wr_digit.blank = wr_blank_i;
`ifdef SEVSEG_BLINK_EN
    wr_digit.blink = wr_blink_i;
`else
    wr_digit.blink = 1'b0;
`endif
  end

  // Indices with no matching digit complete the handshake but write nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= {NUM_DISPLAYS{RESET_DIGIT}};
    end else if (wr_fire) begin
      for (int i = 0; i < NUM_DISPLAYS; i++) begin
        if (wr_index_i == IDX_W'(i)) begin
          shadow_q[i] <= wr_digit;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= {NUM_DISPLAYS{RESET_DIGIT}};
    end else if (state_q == APPLY) begin
      active_q <= shadow_q;
    end
  end

`ifdef SEVSEG_BLINK_EN
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [BLK_W-1:0] blink_cnt_q;
  logic             blink_phase_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
    end else if (frame_tick_o) begin
      if (blink_cnt_q == BLK_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_q   <= '0;
        blink_phase_q <= ~blink_phase_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end
    end
  end

  assign blink_on = blink_phase_q;
`else
  localparam int unused_blink_frames = BLINK_FRAMES;
  logic unused_blink;

  assign blink_on     = 1'b1;
  assign unused_blink = ^{wr_blink_i, active_q};
`endif

  seven_segment_lz_blank #(
    .NUM_DISPLAYS (NUM_DISPLAYS)
  ) u_lz_blank (
    .en_i     (lz_blank_en_i),
    .digits_i (active_q),
    .dark_o   (lz_dark)
  );

  // Output decode straight from the active buffer
  always_comb begin
    displays_o = '0;
    dots_o     = '0;
    for (int i = 0; i < NUM_DISPLAYS; i++) begin
      displays_o[i] = hex_to_seg(active_q[i].value);
      dots_o[i]     = active_q[i].dot;
      if (active_q[i].blank || lz_dark[i]) begin
        displays_o[i] = 7'h00;
      end
      if (active_q[i].blink && !blink_on) begin
        displays_o[i] = 7'h00;
        dots_o[i]     = 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seven_segment_frame_ctrl.sv
// ============================================================================
// Module : tb_seven_segment_frame_ctrl
// Brief  : Directed self-checking bench, NUM_DISPLAYS=4, REFRESH_PERIOD=8.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_seven_segment_frame_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr_valid = 1'b0;
  logic wr_ready;
  logic [1:0] wr_index = '0;
  logic [3:0] wr_value = '0;
  logic wr_dot = 1'b0;
  logic wr_blank = 1'b0;
  logic wr_blink = 1'b0;
  logic commit_valid = 1'b0;
  logic commit_ready;
  logic lz_blank_en = 1'b0;
  logic pending;
  logic frame_tick;
  logic [3:0][6:0] displays;
  logic [3:0] dots;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  // Free-running cycle count since reset release; equals the frame counter unwrapped.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  seven_segment_frame_ctrl #(
    .NUM_DISPLAYS   (4),
    .REFRESH_PERIOD (8),
    .BLINK_FRAMES   (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .wr_valid_i     (wr_valid),
    .wr_ready_o     (wr_ready),
    .wr_index_i     (wr_index),
    .wr_value_i     (wr_value),
    .wr_dot_i       (wr_dot),
    .wr_blank_i     (wr_blank),
    .wr_blink_i     (wr_blink),
    .commit_valid_i (commit_valid),
    .commit_ready_o (commit_ready),
    .lz_blank_en_i  (lz_blank_en),
    .pending_o      (pending),
    .frame_tick_o   (frame_tick),
    .displays_o     (displays),
    .dots_o         (dots)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_digit(input logic [1:0] idx, input logic [3:0] val,
                             input logic dot, input logic blank, input logic blink);
    wr_index = idx; wr_value = val; wr_dot = dot; wr_blank = blank; wr_blink = blink;
    wr_valid = 1'b1;
    total++;
    if (wr_ready !== 1'b1) begin bad++; $display("FAIL write_ready idx=%0d got=%b want=1", idx, wr_ready); end
    step();
    wr_valid = 1'b0; wr_blink = 1'b0;
  endtask

  task automatic commit();
    commit_valid = 1'b1;
    step();
    commit_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (pending === 1'b1 && n < 40) begin step(); n++; end
    total++;
    if (pending !== 1'b0) begin bad++; $display("FAIL wait_idle timeout pending=%b", pending); end
  endtask

  task automatic test_reset();
    repeat (3) step();
    total++; if (displays !== '0) begin bad++; $display("FAIL rst_displays got=%h want=0", displays); end
    total++; if (dots !== 4'b0) begin bad++; $display("FAIL rst_dots got=%b want=0000", dots); end
    total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL rst_wr_ready got=%b want=0", wr_ready); end
    total++; if (commit_ready !== 1'b0) begin bad++; $display("FAIL rst_commit_ready got=%b want=0", commit_ready); end
    total++; if (pending !== 1'b0) begin bad++; $display("FAIL rst_pending got=%b want=0", pending); end
    total++; if (frame_tick !== 1'b0) begin bad++; $display("FAIL rst_tick got=%b want=0", frame_tick); end
    rst = 1'b0;
    #1;
    total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL rel_wr_ready got=%b want=1", wr_ready); end
    total++; if (commit_ready !== 1'b1) begin bad++; $display("FAIL rel_commit_ready got=%b want=1", commit_ready); end
    for (int k = 0; k < 16; k++) begin
      total++;
      if (frame_tick !== ((cyc % 8) == 7)) begin
        bad++; $display("FAIL tick_period cyc=%0d got=%b want=%b", cyc, frame_tick, (cyc % 8) == 7);
      end
      step();
    end
  endtask

  task automatic test_basic_commit();
    int n = 0;
    logic early = 1'b0;
    write_digit(2'd0, 4'h5, 1'b0, 1'b0, 1'b0);
    write_digit(2'd1, 4'hA, 1'b1, 1'b0, 1'b0);
    total++; if (displays !== '0) begin bad++; $display("FAIL shadow_leak got=%h want=0", displays); end
    commit();
    total++; if (pending !== 1'b1) begin bad++; $display("FAIL basic_pending got=%b want=1", pending); end
    total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL basic_wr_ready got=%b want=0", wr_ready); end
    total++; if (commit_ready !== 1'b0) begin bad++; $display("FAIL basic_commit_ready got=%b want=0", commit_ready); end
    while (pending === 1'b1 && n < 20) begin
      if (displays !== '0 || dots !== 4'b0) early = 1'b1;
      step(); n++;
    end
    total++; if (early !== 1'b0) begin bad++; $display("FAIL basic_early_update got=%b want=0", early); end
    total++; if (n < 1 || n > 9) begin bad++; $display("FAIL basic_latency got=%0d want=1..9", n); end
    total++; if (displays[0] !== 7'h6D) begin bad++; $display("FAIL basic_d0 got=%h want=6d", displays[0]); end
    total++; if (displays[1] !== 7'h77) begin bad++; $display("FAIL basic_d1 got=%h want=77", displays[1]); end
    total++; if (displays[3:2] !== '0) begin bad++; $display("FAIL basic_d32 got=%h want=0", displays[3:2]); end
    total++; if (dots !== 4'b0010) begin bad++; $display("FAIL basic_dots got=%b want=0010", dots); end
  endtask

  task automatic test_commit_on_tick();
    int n = 0;
    write_digit(2'd0, 4'h3, 1'b0, 1'b0, 1'b0);
    while (frame_tick !== 1'b1 && n < 20) begin step(); n++; end
    total++; if (frame_tick !== 1'b1) begin bad++; $display("FAIL tick_wait got=%b want=1", frame_tick); end
    commit();
    n = 0;
    while (displays[0] === 7'h6D && n < 30) begin step(); n++; end
    total++; if (n !== 9) begin bad++; $display("FAIL tick_commit_latency got=%0d want=9", n); end
    total++; if (displays[0] !== 7'h4F) begin bad++; $display("FAIL tick_commit_d0 got=%h want=4f", displays[0]); end
  endtask

  task automatic test_lz_blank();
    lz_blank_en = 1'b1;
    write_digit(2'd3, 4'h0, 1'b0, 1'b0, 1'b0);
    write_digit(2'd2, 4'h0, 1'b0, 1'b0, 1'b0);
    write_digit(2'd1, 4'h4, 1'b0, 1'b0, 1'b0);
    write_digit(2'd0, 4'h0, 1'b0, 1'b0, 1'b0);
    commit();
    wait_idle();
    total++; if (displays !== {7'h00, 7'h00, 7'h66, 7'h3F}) begin bad++; $display("FAIL lz_on got=%h want=%h", displays, {7'h00, 7'h00, 7'h66, 7'h3F}); end
    lz_blank_en = 1'b0;
    #1;
    total++; if (displays !== {7'h3F, 7'h3F, 7'h66, 7'h3F}) begin bad++; $display("FAIL lz_off got=%h want=%h", displays, {7'h3F, 7'h3F, 7'h66, 7'h3F}); end
    lz_blank_en = 1'b1;
    write_digit(2'd3, 4'h9, 1'b0, 1'b1, 1'b0);
    write_digit(2'd2, 4'h0, 1'b1, 1'b0, 1'b0);
    write_digit(2'd1, 4'h0, 1'b0, 1'b0, 1'b0);
    commit();
    wait_idle();
    total++; if (displays !== {7'h00, 7'h00, 7'h00, 7'h3F}) begin bad++; $display("FAIL lz_all_zero got=%h want=%h", displays, {7'h00, 7'h00, 7'h00, 7'h3F}); end
    total++; if (dots !== 4'b0100) begin bad++; $display("FAIL lz_dots got=%b want=0100", dots); end
    lz_blank_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    wr_index = 2'd2; wr_value = 4'h7; wr_dot = 1'b0; wr_blank = 1'b0;
    wr_valid = 1'b1; commit_valid = 1'b1;
    total++; if ({wr_ready, commit_ready} !== 2'b11) begin bad++; $display("FAIL b2b_ready got=%b want=11", {wr_ready, commit_ready}); end
    step();
    wr_valid = 1'b0; commit_valid = 1'b0;
    wait_idle();
    total++; if (displays[2] !== 7'h07) begin bad++; $display("FAIL b2b_d2 got=%h want=07", displays[2]); end
    write_digit(2'd0, 4'h9, 1'b1, 1'b0, 1'b0);
    commit();
    total++; if (pending !== 1'b1) begin bad++; $display("FAIL rstp_pending_before got=%b want=1", pending); end
    rst = 1'b1;
    repeat (2) step();
    total++; if (pending !== 1'b0) begin bad++; $display("FAIL rstp_pending got=%b want=0", pending); end
    total++; if (displays !== '0 || dots !== 4'b0) begin bad++; $display("FAIL rstp_outputs got=%h/%b want=0/0000", displays, dots); end
    rst = 1'b0;
    repeat (20) step();
    total++; if (displays !== '0 || pending !== 1'b0) begin bad++; $display("FAIL rstp_discard got=%h/%b want=0/0", displays, pending); end
  endtask

  task automatic test_blink();
    logic on;
    logic [6:0] exp_seg;
    logic exp_dot;
    write_digit(2'd0, 4'h8, 1'b1, 1'b0, 1'b1);
    commit();
    wait_idle();
    for (int k = 0; k < 48; k++) begin
      on = ((cyc / 16) % 2) == 0;
`ifdef SEVSEG_BLINK_EN
      exp_seg = on ? 7'h7F : 7'h00;
      exp_dot = on;
`else
      exp_seg = 7'h7F;
      exp_dot = 1'b1;
`endif
      total++;
      if (displays[0] !== exp_seg || dots[0] !== exp_dot) begin
        bad++; $display("FAIL blink cyc=%0d got=%h/%b want=%h/%b", cyc, displays[0], dots[0], exp_seg, exp_dot);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_basic_commit();
    test_commit_on_tick();
    test_lz_blank();
    test_back_to_back();
    test_blink();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
